vrf_operand_streamer: RTL and testbench
=======================================

# vrf_operand_streamer

Vector-register-file operand stage placed directly upstream of the floating-point PE. It buffers one operand vector written by the host or loader, then replays it element by element in lock-step with the incoming data stream. It registers both paths so the PE sees a cycle-aligned stream operand, VRF operand and scalar operand, each with its own valid and last flag.

## Interface
Parameters:
- DWIDTH, 64 — element width (double-precision float, opaque to this block)
- DEPTH, 256 — VRF entries; power of two
- AW, 8 — address width, log2(DEPTH)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- wr_en  in  1  VRF write strobe
- wr_addr  in  AW  VRF write address
- wr_data  in  DWIDTH  VRF write data
- cfg_start  in  1  one-cycle pulse; arms a replay
- cfg_base  in  AW  first VRF address of the vector
- cfg_len  in  AW+1  vector length, legal range 1..DEPTH
- cfg_repeat  in  1  1 = restart at cfg_base after cfg_len elements until stream last
- cfg_scalar  in  DWIDTH  scalar operand, sampled on cfg_start
- s_data  in  DWIDTH  stream element
- s_valid  in  1  stream element valid
- s_last  in  1  stream last element
- o_sdata / o_svalid / o_slast  out  DWIDTH/1/1  stream path, registered
- o_vdata / o_vvalid / o_vlast  out  DWIDTH/1/1  VRF operand path
- o_scalar  out  DWIDTH  latched scalar (feeds PE inp3)
- busy  out  1  replay armed or running
- done  out  1  one-cycle pulse at replay completion
- err_len  out  1  sticky: cfg_start with cfg_len = 0 or > DEPTH
- err_trunc  out  1  sticky: stream last arrived before cfg_len elements (non-repeat mode)

## Operation
- VRF: DEPTH x DWIDTH synchronous RAM with read-first behaviour. A same-cycle write and read to one address returns the old data. Contents are not reset.
- FSM states:
  - IDLE: busy=0. On cfg_start with legal cfg_len: latch base, len, repeat and scalar; idx=0; go to RUN. On cfg_start with an illegal length: set err_len and stay in IDLE.
  - RUN: busy=1. Each cycle with s_valid=1:
    - read address (base+idx) mod DEPTH; wrap-around past DEPTH-1 goes to 0.
    - vlast marked when idx = len-1.
    - idx then advances. When idx reaches len-1 it either wraps to 0 (repeat=1) or ends the replay (repeat=0).
  - Leaving RUN:
    - non-repeat: exit after the element with idx = len-1, or on s_last if that comes first. The early s_last case sets err_trunc.
    - repeat: exit on s_last only.
    - On exit go to IDLE, assert done the following cycle, and set busy=0 the same cycle as done.
- Cycles with s_valid=0 in RUN: no read, idx holds, o_vvalid=0.
- Stream elements outside RUN pass through on the stream path with o_vvalid=0.
- cfg_start while busy=1: ignored; no error flag.
- o_vlast = (idx = len-1) or, in repeat mode, s_last. In repeat mode the PE therefore sees coincident last flags on both paths.
- Arithmetic: address is AW-bit modulo addition. idx compares against len-1 in AW+1 bits, so len = DEPTH covers all entries.

## Timing
- Reset values:
  - o_sdata, o_vdata, o_scalar = 0
  - all valid/last outputs = 0
  - busy, done, err_len, err_trunc = 0
  - FSM in IDLE, idx = 0
- Latency: exactly 1 cycle from s_valid/s_data/s_last to o_svalid/o_sdata/o_slast. o_vdata/o_vvalid/o_vlast appear in that same cycle (RAM read issued in the input cycle).
- Throughput: one element per cycle; no backpressure (the PE pipeline has none).
- cfg_start accepted in cycle N: the first replayable stream element is the one presented in cycle N+1.
- done: pulses in the cycle after the final o_vvalid of a replay.
- err flags: clear only on rst.
- rst asserted mid-replay: all outputs drop to 0 asynchronously, FSM returns to IDLE, no done pulse.

## Test plan
- Write VRF[0..7] = 1.0..8.0, start base=0 len=8 repeat=0, stream 8 valid elements back-to-back:
  - o_vdata = 1.0..8.0 aligned with o_sdata, each one cycle after input.
  - o_vlast on the 8th element.
  - done the following cycle.
- Wrap: base=254, len=4, DEPTH=256 -> reads addresses 254, 255, 0, 1 in that order.
- Gapped stream (s_valid 1,0,1,1,0,1), len=4:
  - o_vvalid mirrors o_svalid.
  - idx advances only on valid cycles.
  - o_vlast on the 4th valid element.
- Repeat mode, len=3, stream of 7 elements with s_last on the 7th:
  - VRF pattern a,b,c,a,b,c,a.
  - o_vlast on elements 3 and 6 (idx wrap) and on 7 (s_last).
  - No err_trunc.
- Non-repeat, len=5, s_last on the 3rd element -> err_trunc=1, done pulse, FSM back to IDLE.
- Edge cases:
  - cfg_start with len=0 -> err_len=1, busy stays 0.
  - cfg_start while busy -> ignored.
  - Write to the address being read in the same cycle -> old value out.
  - rst mid-replay -> all outputs 0 within the reset assertion.

Source files
------------

// File: rtl/vrf_operand_streamer.sv
// vrf_operand_streamer: buffers one operand vector in a local VRF and replays
// it element by element alongside the incoming data stream, so the PE sees a
// cycle-aligned stream operand, VRF operand and scalar operand.
//
// Handshake: s_valid qualifies s_data/s_last for one cycle; there is no ready
// (no backpressure). Every accepted element produces o_svalid exactly one
// cycle later, and during a replay o_vvalid in that same cycle.
module vrf_operand_streamer #(
    parameter int DWIDTH = 64,
    parameter int DEPTH  = 256,
    parameter int AW     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              cfg_start,
    input  logic [AW-1:0]     cfg_base,
    input  logic [AW:0]       cfg_len,
    input  logic              cfg_repeat,
    input  logic [DWIDTH-1:0] cfg_scalar,
    input  logic [DWIDTH-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic [DWIDTH-1:0] o_sdata,
    output logic              o_svalid,
    output logic              o_slast,
    output logic [DWIDTH-1:0] o_vdata,
    output logic              o_vvalid,
    output logic              o_vlast,
    output logic [DWIDTH-1:0] o_scalar,
    output logic              busy,
    output logic              done,
    output logic              err_len,
    output logic              err_trunc
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [AW:0] LEN_MAX = (AW + 1)'(DEPTH);
    localparam logic [AW:0] LEN_ONE = (AW + 1)'(1);

    state_t            state, state_next;
    logic [AW-1:0]     base_q;
    logic [AW:0]       len_q;
    logic              rpt_q;
    logic [AW-1:0]     idx, idx_next;
    logic              done_pend;     // replay ended last cycle; done fires next
    logic [AW-1:0]     rd_addr;
    logic              accept, len_bad, set_err_len, hit, at_end;
    logic              exit_run, set_trunc, vlast_next;
    logic [DWIDTH-1:0] mem [DEPTH];

    // busy covers the gap between leaving RUN and the done pulse, so that
    // busy falls in the same cycle done rises and cfg_start stays ignored.
    assign busy    = (state == RUN) || done_pend;
    assign rd_addr = base_q + idx;    // AW-bit add wraps past DEPTH-1 to 0

    // Next-state, index update and per-element flags.
    always_comb begin
        state_next  = state;
        idx_next    = idx;
        accept      = 1'b0;
        set_err_len = 1'b0;
        hit         = 1'b0;
        exit_run    = 1'b0;
        set_trunc   = 1'b0;
        vlast_next  = 1'b0;
        len_bad     = (cfg_len == '0) || (cfg_len > LEN_MAX);
        at_end      = ({1'b0, idx} == (len_q - LEN_ONE));
        case (state)
            IDLE: begin
                if (cfg_start && !done_pend) begin
                    if (len_bad) begin
                        set_err_len = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        idx_next   = '0;
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (s_valid) begin
                    hit        = 1'b1;
                    vlast_next = at_end || (rpt_q && s_last);
                    if (rpt_q) begin
                        idx_next = at_end ? '0 : idx + 1'b1;
                        exit_run = s_last;
                    end else begin
                        idx_next  = idx + 1'b1;
                        exit_run  = at_end || s_last;
                        set_trunc = s_last && !at_end;
                    end
                    if (exit_run) begin
                        idx_next   = '0;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Replay configuration, element index and completion pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q    <= '0;
            len_q     <= '0;
            rpt_q     <= 1'b0;
            o_scalar  <= '0;
            idx       <= '0;
            done_pend <= 1'b0;
            done      <= 1'b0;
        end else begin
            if (accept) begin
                base_q   <= cfg_base;
                len_q    <= cfg_len;
                rpt_q    <= cfg_repeat;
                o_scalar <= cfg_scalar;
            end
            idx       <= idx_next;
            done_pend <= exit_run;
            done      <= done_pend;
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_len   <= 1'b0;
            err_trunc <= 1'b0;
        end else begin
            if (set_err_len) err_len   <= 1'b1;
            if (set_trunc)   err_trunc <= 1'b1;
        end
    end

    // Stream path: one register stage, always passes through.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_sdata  <= '0;
            o_svalid <= 1'b0;
            o_slast  <= 1'b0;
        end else begin
            o_sdata  <= s_data;
            o_svalid <= s_valid;
            o_slast  <= s_last;
        end
    end

    // VRF operand path: read issued in the input cycle, so it lines up with
    // the registered stream path. The read samples mem before this edge's
    // write lands, which gives read-first behaviour on an address collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_vdata  <= '0;
            o_vvalid <= 1'b0;
            o_vlast  <= 1'b0;
        end else begin
            o_vvalid <= hit;
            o_vlast  <= vlast_next;
            if (hit) o_vdata <= mem[rd_addr];
        end
    end

    // VRF write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

endmodule

// File: tb/tb_vrf_operand_streamer.sv
// Self-checking bench for vrf_operand_streamer. The reference model tracks
// the replay as "k-th valid element since start reads (base + k mod len) mod
// DEPTH" and keeps a shadow copy of the VRF.
module tb_vrf_operand_streamer;

    localparam int DW    = 64;
    localparam int DEPTH = 256;
    localparam int AW    = 8;
    localparam int W     = 2 * DW + 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          cfg_start = 1'b0;
    logic [AW-1:0] cfg_base = '0;
    logic [AW:0]   cfg_len = '0;
    logic          cfg_repeat = 1'b0;
    logic [DW-1:0] cfg_scalar = '0;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic [DW-1:0] o_sdata, o_vdata, o_scalar;
    logic          o_svalid, o_slast, o_vvalid, o_vlast;
    logic          busy, done, err_len, err_trunc;

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard and reference model state.
    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  obs_word;
    logic [DW-1:0] model_mem [DEPTH];
    bit            m_active = 0;
    bit            m_rpt = 0;
    int            m_base = 0;
    int            m_len = 1;
    int            m_k = 0;
    bit            m_trunc = 0;
    bit            m_err_len = 0;
    logic [DW-1:0] m_scalar = '0;

    vrf_operand_streamer #(.DWIDTH(DW), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cfg_start(cfg_start), .cfg_base(cfg_base), .cfg_len(cfg_len),
        .cfg_repeat(cfg_repeat), .cfg_scalar(cfg_scalar),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .o_sdata(o_sdata), .o_svalid(o_svalid), .o_slast(o_slast),
        .o_vdata(o_vdata), .o_vvalid(o_vvalid), .o_vlast(o_vlast),
        .o_scalar(o_scalar), .busy(busy), .done(done),
        .err_len(err_len), .err_trunc(err_trunc)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [DW-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // ---------------- driver tasks (all called at a negedge) ----------------
    task automatic idle_cycle();
        s_valid = 1'b0; s_last = 1'b0; wr_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic vrf_write(input int addr, input logic [DW-1:0] data);
        wr_en = 1'b1; wr_addr = addr[AW-1:0]; wr_data = data;
        @(negedge clk);
        wr_en = 1'b0;
        model_mem[addr] = data;
    endtask

    task automatic start_cfg(input int base, input int len, input bit rpt, input logic [DW-1:0] sc);
        cfg_start = 1'b1; cfg_base = base[AW-1:0]; cfg_len = len[AW:0];
        cfg_repeat = rpt; cfg_scalar = sc;
        s_valid = 1'b0; s_last = 1'b0;
        @(negedge clk);
        cfg_start = 1'b0;
        if (len == 0 || len > DEPTH) begin
            m_err_len = 1;
        end else begin
            m_active = 1; m_base = base; m_len = len; m_rpt = rpt; m_k = 0; m_scalar = sc;
        end
    endtask

    // One input cycle; pushes the model's expectation and captures the
    // registered outputs one cycle later.
    task automatic drive_cycle(input logic sv, input logic [DW-1:0] sd, input logic sl,
                               input logic we, input int wa, input logic [DW-1:0] wd);
        int pos;
        logic evv, evl;
        logic [DW-1:0] evd;
        s_valid = sv; s_data = sd; s_last = sl;
        wr_en = we; wr_addr = wa[AW-1:0]; wr_data = wd;
        evv = 1'b0; evl = 1'b0; evd = '0;
        if (m_active && sv) begin
            pos = m_k % m_len;
            evv = 1'b1;
            evd = model_mem[(m_base + pos) % DEPTH];
            evl = (pos == m_len - 1) || (m_rpt && sl);
            m_k++;
            if (m_rpt) begin
                if (sl) m_active = 0;
            end else if (pos == m_len - 1) begin
                m_active = 0;
            end else if (sl) begin
                m_active = 0; m_trunc = 1;
            end
        end
        if (we) model_mem[wa] = wd;
        exp_q.push_back({sv, sl, evv, evl, sv ? sd : {DW{1'b0}}, evd});
        @(negedge clk);
        obs_word = {o_svalid, o_slast, o_vvalid, o_vlast,
                    o_svalid ? o_sdata : {DW{1'b0}}, o_vvalid ? o_vdata : {DW{1'b0}}};
        s_valid = 1'b0; s_last = 1'b0; wr_en = 1'b0;
    endtask

    // Collects {busy,done} over the cycle after the final output and the next two.
    task automatic tail_obs(output logic [5:0] t);
        t[5:4] = {busy, done};
        idle_cycle();
        t[3:2] = {busy, done};
        idle_cycle();
        t[1:0] = {busy, done};
    endtask

    // ------------------------------- tests -------------------------------
    task automatic test_reset();
        logic [3*DW+8-1:0] all;
        repeat (2) @(negedge clk);
        all = {o_sdata, o_svalid, o_slast, o_vdata, o_vvalid, o_vlast, o_scalar,
               busy, done, err_len, err_trunc};
        n_checks++;
        if (all !== '0) begin
            n_errors++; $display("FAIL reset_outputs: got %h expected 0", all);
        end
        rst = 1'b0;
        idle_cycle();
        n_checks++;
        if ({busy, done, o_vvalid} !== 3'b000) begin
            n_errors++; $display("FAIL reset_idle: got %b expected 000", {busy, done, o_vvalid});
        end
    endtask

    task automatic init_vrf();
        for (int a = 0; a < DEPTH; a++) vrf_write(a, rnd64());
    endtask

    task automatic test_basic();
        logic [W-1:0] e;
        logic [5:0] t;
        logic [DW-1:0] sc;
        drive_cycle(1'b1, rnd64(), 1'b0, 1'b0, 0, '0);
        e = exp_q.pop_front(); n_checks++;
        if (obs_word !== e) begin n_errors++; $display("FAIL basic_passthrough: got %h expected %h", obs_word, e); end
        for (int i = 0; i < 8; i++) vrf_write(i, $realtobits(real'(i + 1)));
        sc = rnd64();
        start_cfg(0, 8, 1'b0, sc);
        n_checks++;
        if ({busy, o_scalar} !== {1'b1, sc}) begin
            n_errors++; $display("FAIL basic_start: got %b/%h expected 1/%h", busy, o_scalar, sc);
        end
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1'b1, rnd64(), 1'b0, 1'b0, 0, '0);
            e = exp_q.pop_front(); n_checks++;
            if (obs_word !== e) begin n_errors++; $display("FAIL basic_elem%0d: got %h expected %h", i, obs_word, e); end
        end
        tail_obs(t); n_checks++;
        if (t !== 6'b10_01_00) begin n_errors++; $display("FAIL basic_done: got %b expected 100100", t); end
    endtask

    task automatic test_wrap();
        logic [W-1:0] e;
        logic [5:0] t;
        start_cfg(254, 4, 1'b0, rnd64());
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, rnd64(), 1'b0, 1'b0, 0, '0);
            e = exp_q.pop_front(); n_checks++;
            if (obs_word !== e) begin n_errors++; $display("FAIL wrap_elem%0d: got %h expected %h", i, obs_word, e); end
        end
        tail_obs(t); n_checks++;
        if (t !== 6'b10_01_00) begin n_errors++; $display("FAIL wrap_done: got %b expected 100100", t); end
    endtask

    task automatic test_gapped();
        logic [W-1:0] e;
        logic [5:0] t;
        logic [5:0] pat;
        pat = 6'b101101;
        start_cfg(100, 4, 1'b0, rnd64());
        for (int i = 0; i < 6; i++) begin
            drive_cycle(pat[5 - i], rnd64(), 1'b0, 1'b0, 0, '0);
            e = exp_q.pop_front(); n_checks++;
            if (obs_word !== e) begin n_errors++; $display("FAIL gapped_cyc%0d: got %h expected %h", i, obs_word, e); end
        end
        tail_obs(t); n_checks++;
        if (t !== 6'b10_01_00) begin n_errors++; $display("FAIL gapped_done: got %b expected 100100", t); end
    endtask

    task automatic test_repeat();
        logic [W-1:0] e;
        logic [5:0] t;
        start_cfg(50, 3, 1'b1, rnd64());
        for (int i = 0; i < 7; i++) begin
            drive_cycle(1'b1, rnd64(), i == 6, 1'b0, 0, '0);
            e = exp_q.pop_front(); n_checks++;
            if (obs_word !== e) begin n_errors++; $display("FAIL repeat_elem%0d: got %h expected %h", i, obs_word, e); end
            n_checks++;
            if (busy !== 1'b1) begin n_errors++; $display("FAIL repeat_busy%0d: got %b expected 1", i, busy); end
        end
        tail_obs(t); n_checks++;
        if ({t, err_trunc} !== {6'b10_01_00, m_trunc}) begin
            n_errors++; $display("FAIL repeat_done: got %b/%b expected 100100/%b", t, err_trunc, m_trunc);
        end
    endtask

    task automatic test_trunc();
        logic [W-1:0] e;
        logic [5:0] t;
        start_cfg(20, 5, 1'b0, rnd64());
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, rnd64(), i == 2, 1'b0, 0, '0);
            e = exp_q.pop_front(); n_checks++;
            if (obs_word !== e) begin n_errors++; $display("FAIL trunc_elem%0d: got %h expected %h", i, obs_word, e); end
        end
        tail_obs(t); n_checks++;
        if ({t, err_trunc} !== {6'b10_01_00, m_trunc}) begin
            n_errors++; $display("FAIL trunc_done: got %b/%b expected 100100/%b", t, err_trunc, m_trunc);
        end
    endtask

    task automatic test_collision();
        logic [W-1:0] e;
        logic [5:0] t;
        start_cfg(10, 3, 1'b0, rnd64());
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, rnd64(), 1'b0, i == 1, 11, rnd64());
            e = exp_q.pop_front(); n_checks++;
            if (obs_word !== e) begin n_errors++; $display("FAIL collide_elem%0d: got %h expected %h", i, obs_word, e); end
        end
        tail_obs(t);
        start_cfg(11, 1, 1'b0, rnd64());
        drive_cycle(1'b1, rnd64(), 1'b0, 1'b0, 0, '0);
        e = exp_q.pop_front(); n_checks++;
        if (obs_word !== e) begin n_errors++; $display("FAIL collide_newval: got %h expected %h", obs_word, e); end
        tail_obs(t); n_checks++;
        if (t !== 6'b10_01_00) begin n_errors++; $display("FAIL collide_done: got %b expected 100100", t); end
    endtask

    task automatic test_busy_ignore();
        logic [W-1:0] e;
        logic [DW-1:0] sc;
        sc = rnd64();
        start_cfg(40, 4, 1'b0, sc);
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                cfg_start = 1'b1; cfg_base = 8'd99; cfg_len = '0; cfg_scalar = ~sc;
            end
            drive_cycle(1'b1, rnd64(), 1'b0, 1'b0, 0, '0);
            cfg_start = 1'b0;
            e = exp_q.pop_front(); n_checks++;
            if (obs_word !== e) begin n_errors++; $display("FAIL busyign_elem%0d: got %h expected %h", i, obs_word, e); end
        end
        n_checks++;
        if ({err_len, o_scalar} !== {1'b0, sc}) begin
            n_errors++; $display("FAIL busyign_flags: got %b/%h expected 0/%h", err_len, o_scalar, sc);
        end
        // Start during the busy tail before done must also be ignored.
        cfg_start = 1'b1; cfg_base = 8'd0; cfg_len = 9'd2; cfg_repeat = 1'b0;
        idle_cycle();
        cfg_start = 1'b0;
        n_checks++;
        if ({busy, done} !== 2'b01) begin n_errors++; $display("FAIL busyign_done: got %b expected 01", {busy, done}); end
        idle_cycle();
        n_checks++;
        if ({busy, done} !== 2'b00) begin n_errors++; $display("FAIL busyign_tail: got %b expected 00", {busy, done}); end
    endtask

    task automatic test_len_err();
        start_cfg(0, 0, 1'b0, rnd64());
        n_checks++;
        if ({err_len, busy} !== {m_err_len, 1'b0}) begin
            n_errors++; $display("FAIL lenerr_zero: got %b expected %b0", {err_len, busy}, m_err_len);
        end
        start_cfg(0, DEPTH + 1, 1'b0, rnd64());
        idle_cycle();
        n_checks++;
        if ({err_len, busy, done} !== {m_err_len, 2'b00}) begin
            n_errors++; $display("FAIL lenerr_big: got %b expected %b00", {err_len, busy, done}, m_err_len);
        end
    endtask

    task automatic test_full_len();
        logic [W-1:0] e;
        logic [5:0] t;
        int errs;
        errs = 0;
        start_cfg($urandom_range(0, DEPTH - 1), DEPTH, 1'b0, rnd64());
        for (int i = 0; i < DEPTH; i++) begin
            drive_cycle(1'b1, rnd64(), 1'b0, 1'b0, 0, '0);
            e = exp_q.pop_front(); n_checks++;
            if (obs_word !== e) begin n_errors++; $display("FAIL full_elem%0d: got %h expected %h", i, obs_word, e); end
        end
        tail_obs(t); n_checks++;
        if (t !== 6'b10_01_00) begin n_errors++; $display("FAIL full_done: got %b expected 100100", t); end
    endtask

    task automatic test_rst_mid();
        logic [W-1:0] e;
        logic [3*DW+8-1:0] all;
        start_cfg(0, 8, 1'b0, rnd64());
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, rnd64(), 1'b0, 1'b0, 0, '0);
            e = exp_q.pop_front(); n_checks++;
            if (obs_word !== e) begin n_errors++; $display("FAIL rstmid_elem%0d: got %h expected %h", i, obs_word, e); end
        end
        s_valid = 1'b1; s_data = rnd64();
        #2 rst = 1'b1;
        #1;
        all = {o_sdata, o_svalid, o_slast, o_vdata, o_vvalid, o_vlast, o_scalar,
               busy, done, err_len, err_trunc};
        n_checks++;
        if (all !== '0) begin n_errors++; $display("FAIL rstmid_async: got %h expected 0", all); end
        @(negedge clk);
        rst = 1'b0; s_valid = 1'b0;
        m_active = 0; m_trunc = 0; m_err_len = 0;
        for (int i = 0; i < 3; i++) begin
            idle_cycle();
            n_checks++;
            if ({busy, done, o_vvalid} !== 3'b000) begin
                n_errors++; $display("FAIL rstmid_after%0d: got %b expected 000", i, {busy, done, o_vvalid});
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] e;
        logic [5:0] t;
        int len, n_el, sent;
        bit rpt, sv;
        for (int it = 0; it < 8; it++) begin
            len = $urandom_range(1, 10);
            rpt = $urandom_range(0, 1);
            n_el = rpt ? $urandom_range(1, 3 * len) : len;
            start_cfg($urandom_range(0, DEPTH - 1), len, rpt, rnd64());
            sent = 0;
            while (sent < n_el) begin
                sv = ($urandom_range(0, 3) != 0);
                drive_cycle(sv, rnd64(), sv && rpt && (sent == n_el - 1),
                            $urandom_range(0, 1), $urandom_range(0, DEPTH - 1), rnd64());
                e = exp_q.pop_front(); n_checks++;
                if (obs_word !== e) begin n_errors++; $display("FAIL rand%0d_elem%0d: got %h expected %h", it, sent, obs_word, e); end
                if (sv) sent++;
            end
            tail_obs(t); n_checks++;
            if ({t, err_trunc} !== {6'b10_01_00, m_trunc}) begin
                n_errors++; $display("FAIL rand%0d_done: got %b/%b expected 100100/%b", it, t, err_trunc, m_trunc);
            end
        end
    endtask

    initial begin
        test_reset();
        init_vrf();
        test_basic();
        test_wrap();
        test_gapped();
        test_repeat();
        test_trunc();
        test_collision();
        test_busy_ignore();
        test_len_err();
        test_full_len();
        test_rst_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
